// File: rtl/cam_match_walker_pkg.sv
// Shared types and helpers for the CAM match-vector walker.
package cam_match_walker_pkg;

    // Walker FSM: waiting for a vector, or emitting its hits one by one.
    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } camWalkState_t;

    // Widest match vector the popcount helper accepts; callers zero-extend.
    localparam int unsigned CAM_MAX_DEPTH = 256;

    // Number of set bits in a (zero-extended) match vector.
    function automatic int unsigned cam_popcount(input logic [CAM_MAX_DEPTH-1:0] v);
        int unsigned cnt;
        cnt = 0;
        for (int unsigned i = 0; i < CAM_MAX_DEPTH; i++) begin
            if (v[i]) begin
                cnt = cnt + 1;
            end
        end
        return cnt;
    endfunction

endpackage

// File: rtl/cam_lsb_encoder.sv
// Lowest-set-bit encoder: reports the lowest set index of a vector, the
// vector with that bit removed, and whether at most one bit is set.
module cam_lsb_encoder
    import cam_match_walker_pkg::*;
#(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned INDEX = 5
) (
    input  logic [DEPTH-1:0] vect,
    output logic             any_o,
    output logic [INDEX-1:0] idx_o,
    output logic [DEPTH-1:0] onehotClr_o,
    output logic             single_o
);

    logic [DEPTH-1:0] w_clr;

    // Descending scan so the lowest set bit is the last one written.
    always_comb begin
        idx_o = '0;
        for (int unsigned i = DEPTH; i > 0; i--) begin
            if (vect[i-1]) begin
                idx_o = INDEX'(i - 1);
            end
        end
    end

    // Clearing the lowest set bit: v & (v - 1).
    always_comb begin
        w_clr       = vect & (vect - DEPTH'(1));
        any_o       = |vect;
        onehotClr_o = w_clr;
        single_o    = ~(|w_clr);
    end

endmodule

// File: rtl/cam_match_walker.sv
// Accepts one CAM match vector and walks it lowest-index-first, emitting one
// entry index per output handshake and flagging the final response.
module cam_match_walker
    import cam_match_walker_pkg::*;
#(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned INDEX = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             vectValid_i,
    input  logic [DEPTH-1:0] vect_i,
    output logic             vectReady_o,
    input  logic             flush_i,
    output logic             hitValid_o,
    input  logic             hitReady_i,
    output logic             hit_o,
    output logic [INDEX-1:0] hitIndex_o,
    output logic             last_o,
    output logic [INDEX:0]   matchCount_o,
    output logic             busy_o
);

    camWalkState_t    r_state;
    logic [DEPTH-1:0] r_pending;
    logic [INDEX:0]   r_matchCount;

    logic             w_any;
    logic [INDEX-1:0] w_idx;
    logic [DEPTH-1:0] w_clr;
    logic             w_single;
    logic [INDEX:0]   w_popcnt;

    cam_lsb_encoder #(
        .DEPTH (DEPTH),
        .INDEX (INDEX)
    ) u_enc (
        .vect        (r_pending),
        .any_o       (w_any),
        .idx_o       (w_idx),
        .onehotClr_o (w_clr),
        .single_o    (w_single)
    );

    // Population count of the incoming vector, captured at accept.
    always_comb begin
        w_popcnt = (INDEX+1)'(cam_popcount(CAM_MAX_DEPTH'(vect_i)));
    end

    // FSM and pending-vector update; flush overrides both accept and consume.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_pending    <= '0;
            r_matchCount <= '0;
        end else if (flush_i) begin
            r_state   <= IDLE;
            r_pending <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (vectValid_i) begin
                        r_pending    <= vect_i;
                        r_matchCount <= w_popcnt;
                        r_state      <= EMIT;
                    end
                end
                EMIT: begin
                    if (hitReady_i) begin
                        if (w_single) begin
                            r_state   <= IDLE;
                            r_pending <= '0;
                        end else begin
                            r_pending <= w_clr;
                        end
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_pending <= '0;
                end
            endcase
        end
    end

    // Outputs depend on registered state only; pending is zero in IDLE so the
    // hit fields show the idle values (miss, index 0, last) there.
    always_comb begin
        vectReady_o  = (r_state == IDLE);
        hitValid_o   = (r_state == EMIT);
        busy_o       = (r_state != IDLE);
        hit_o        = w_any;
        hitIndex_o   = w_idx;
        last_o       = w_single;
        matchCount_o = r_matchCount;
    end

endmodule

// File: tb/tb_cam_match_walker.sv
// Directed bench for cam_match_walker: table-driven walks plus hand-written
// backpressure, flush and asynchronous-reset sequences.
module tb_cam_match_walker;

    logic        clk;
    logic        reset;
    logic        vectValid_i;
    logic [31:0] vect_i;
    logic        vectReady_o;
    logic        flush_i;
    logic        hitValid_o;
    logic        hitReady_i;
    logic        hit_o;
    logic [4:0]  hitIndex_o;
    logic        last_o;
    logic [5:0]  matchCount_o;
    logic        busy_o;

    int unsigned total;
    int unsigned bad;

    typedef struct {
        logic [31:0] vect;
        int unsigned cnt;
        int unsigned first_idx;
        int unsigned last_idx;
    } vec_t;

    vec_t tbl[7];

    cam_match_walker #(
        .DEPTH (32),
        .INDEX (5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .vectValid_i  (vectValid_i),
        .vect_i       (vect_i),
        .vectReady_o  (vectReady_o),
        .flush_i      (flush_i),
        .hitValid_o   (hitValid_o),
        .hitReady_i   (hitReady_i),
        .hit_o        (hit_o),
        .hitIndex_o   (hitIndex_o),
        .last_o       (last_o),
        .matchCount_o (matchCount_o),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Offer v with hitReady high, then check every response against a bit-scan model.
    task automatic walk(input logic [31:0] v, input int unsigned exp_cnt,
                        input int unsigned exp_first, input int unsigned exp_last);
        logic [31:0] rem;
        int unsigned nresp;
        int unsigned idx;
        int unsigned bits;
        check("ready_before_walk", {31'd0, vectReady_o}, 32'd1);
        vectValid_i = 1'b1;
        vect_i      = v;
        hitReady_i  = 1'b1;
        @(negedge clk);
        vectValid_i = 1'b0;
        vect_i      = '0;
        check("matchCount", {26'd0, matchCount_o}, exp_cnt);
        rem   = v;
        nresp = (exp_cnt == 0) ? 1 : exp_cnt;
        for (int unsigned k = 0; k < nresp; k++) begin
            idx  = 0;
            bits = 0;
            for (int b = 31; b >= 0; b--) begin
                if (rem[b]) begin
                    idx  = b;
                    bits = bits + 1;
                end
            end
            if (k == 0) check("first_idx", {27'd0, hitIndex_o}, exp_first);
            if (k == nresp - 1) check("last_idx", {27'd0, hitIndex_o}, exp_last);
            check("hitValid", {31'd0, hitValid_o}, 32'd1);
            check("busy", {31'd0, busy_o}, 32'd1);
            check("hit", {31'd0, hit_o}, (rem != 0) ? 32'd1 : 32'd0);
            check("hitIndex", {27'd0, hitIndex_o}, idx);
            check("last", {31'd0, last_o}, (bits <= 1) ? 32'd1 : 32'd0);
            if (rem != 0) rem[idx] = 1'b0;
            @(negedge clk);
        end
        check("ready_after_walk", {31'd0, vectReady_o}, 32'd1);
        check("hitValid_after_walk", {31'd0, hitValid_o}, 32'd0);
        check("busy_after_walk", {31'd0, busy_o}, 32'd0);
        hitReady_i = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        tbl[0] = '{32'h0000_8012,  3,  1, 15};
        tbl[1] = '{32'h0000_0000,  0,  0,  0};
        tbl[2] = '{32'h8000_0001,  2,  0, 31};
        tbl[3] = '{32'hFFFF_FFFF, 32,  0, 31};
        tbl[4] = '{32'h0000_0400,  1, 10, 10};
        tbl[5] = '{32'h5555_5555, 16,  0, 30};
        tbl[6] = '{32'hA000_0000,  2, 29, 31};

        reset       = 1'b0;
        vectValid_i = 1'b0;
        vect_i      = '0;
        flush_i     = 1'b0;
        hitReady_i  = 1'b0;

        // Reset state, held across a clock edge.
        @(negedge clk);
        @(negedge clk);
        check("rst_vectReady", {31'd0, vectReady_o}, 32'd1);
        check("rst_hitValid", {31'd0, hitValid_o}, 32'd0);
        check("rst_hit", {31'd0, hit_o}, 32'd0);
        check("rst_hitIndex", {27'd0, hitIndex_o}, 32'd0);
        check("rst_last", {31'd0, last_o}, 32'd1);
        check("rst_matchCount", {26'd0, matchCount_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            walk(tbl[i].vect, tbl[i].cnt, tbl[i].first_idx, tbl[i].last_idx);
        end

        // Backpressure: outputs hold while hitReady is low.
        vectValid_i = 1'b1;
        vect_i      = 32'h8000_0001;
        hitReady_i  = 1'b0;
        @(negedge clk);
        vectValid_i = 1'b0;
        vect_i      = '0;
        for (int i = 0; i < 3; i++) begin
            check("bp_hitValid", {31'd0, hitValid_o}, 32'd1);
            check("bp_hitIndex", {27'd0, hitIndex_o}, 32'd0);
            check("bp_last", {31'd0, last_o}, 32'd0);
            @(negedge clk);
        end
        hitReady_i = 1'b1;
        check("bp_rel_idx0", {27'd0, hitIndex_o}, 32'd0);
        @(negedge clk);
        check("bp_rel_idx31", {27'd0, hitIndex_o}, 32'd31);
        check("bp_rel_last", {31'd0, last_o}, 32'd1);
        @(negedge clk);
        check("bp_done_ready", {31'd0, vectReady_o}, 32'd1);
        hitReady_i = 1'b0;

        // Flush after 2 of 5 hits (bits 3..7).
        vectValid_i = 1'b1;
        vect_i      = 32'h0000_00F8;
        hitReady_i  = 1'b1;
        @(negedge clk);
        vectValid_i = 1'b0;
        vect_i      = '0;
        check("fl_idx3", {27'd0, hitIndex_o}, 32'd3);
        @(negedge clk);
        check("fl_idx4", {27'd0, hitIndex_o}, 32'd4);
        @(negedge clk);
        check("fl_idx5", {27'd0, hitIndex_o}, 32'd5);
        hitReady_i = 1'b0;
        flush_i    = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        check("fl_hitValid", {31'd0, hitValid_o}, 32'd0);
        check("fl_busy", {31'd0, busy_o}, 32'd0);
        check("fl_ready", {31'd0, vectReady_o}, 32'd1);
        check("fl_matchCount_kept", {26'd0, matchCount_o}, 32'd5);
        // Vector offered together with flush in IDLE must be ignored.
        flush_i     = 1'b1;
        vectValid_i = 1'b1;
        vect_i      = 32'h0000_0001;
        @(negedge clk);
        flush_i     = 1'b0;
        vectValid_i = 1'b0;
        vect_i      = '0;
        check("fl_idle_not_busy", {31'd0, busy_o}, 32'd0);
        check("fl_idle_no_hit", {31'd0, hitValid_o}, 32'd0);
        check("fl_idle_count", {26'd0, matchCount_o}, 32'd5);
        @(negedge clk);
        check("fl_idle_still_idle", {31'd0, busy_o}, 32'd0);
        walk(32'h0000_0006, 2, 1, 2);

        // Asynchronous reset mid-walk, between edges.
        vectValid_i = 1'b1;
        vect_i      = 32'h0000_00F0;
        @(negedge clk);
        vectValid_i = 1'b0;
        vect_i      = '0;
        check("ar_busy_before", {31'd0, busy_o}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("ar_hitValid", {31'd0, hitValid_o}, 32'd0);
        check("ar_ready", {31'd0, vectReady_o}, 32'd1);
        check("ar_busy", {31'd0, busy_o}, 32'd0);
        check("ar_matchCount", {26'd0, matchCount_o}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        walk(32'h0001_0100, 2, 8, 16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
